ula4_issuer: RTL and testbench
==============================

ULA4_ISSUER -- requirements
Module: ula4_issuer

Interface
REQ-001 Parameter: DEPTH, 4, command FIFO entries; power of two, 2..16.
REQ-002 Parameter: SETTLE, 1, cycles operands are held on ALU ports before sampling alu_out; 1..7.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 cmd_valid  input  1  command offered.
REQ-006 cmd_ready  output  1  command accepted at an edge where cmd_valid && cmd_ready.
REQ-007 cmd_op  input  3  operation code; 000 add, 001 sub, 010 mul, 011 div, 100 eq, 101 gt, 110 lt, 111 ne.
REQ-008 cmd_a, cmd_b  input  4 each  operands.
REQ-009 alu_a, alu_b  output  4 each  registered operands driven to the ALU.
REQ-010 alu_op  output  3  registered operation code driven to the ALU.
REQ-011 alu_out  input  4  combinational ALU result.
REQ-012 rsp_valid  output  1  result available.
REQ-013 rsp_ready  input  1  result consumed at an edge where rsp_valid && rsp_ready.
REQ-014 rsp_data  output  4  captured result.
REQ-015 rsp_op  output  3  op code of the returned result.
REQ-016 rsp_dz  output  1  divide-by-zero flag for the returned result.
REQ-017 busy  output  1  high when state is not IDLE.
REQ-018 count  output  clog2(DEPTH)+1  FIFO occupancy.

Function
REQ-019 FIFO: DEPTH entries of {op,a,b}, circular read/write pointers wrapping at DEPTH; strict in-order issue and return.
REQ-020 cmd_ready = (count < DEPTH); no combinational dependence on pop, so a full FIFO never accepts, even on a pop edge.
REQ-021 Simultaneous push and pop: count unchanged, both pointers advance.
REQ-022 FSM states: IDLE, ISSUE, RESP.
REQ-023 IDLE: on an edge with count != 0, pop head into alu_op/alu_a/alu_b, load settle counter with SETTLE, go ISSUE; no FIFO bypass (a command accepted at edge N pops at edge N+1 at the earliest).
REQ-024 ISSUE: counter decrements each edge; on the edge where counter == 1, capture rsp_data/rsp_op/rsp_dz, set rsp_valid, go RESP.
REQ-025 RESP: rsp_valid, rsp_data, rsp_op, rsp_dz held stable until handshake; on handshake edge clear rsp_valid and, if count != 0, pop next entry and go ISSUE directly (back-to-back), else go IDLE.
REQ-026 alu_a/alu_b/alu_op change only on pop edges; they hold the last issued values in IDLE, ISSUE and RESP.
REQ-027 Latency with SETTLE=1 and idle FIFO: rsp_valid high 2 edges after cmd acceptance; sustained throughput one result per SETTLE+1 cycles with rsp_ready held high.
REQ-028 Divide by zero: when alu_op == 011 and alu_b == 0, rsp_dz = 1 and rsp_data = 0 regardless of alu_out; otherwise rsp_dz = 0 and rsp_data = alu_out.
REQ-029 No arithmetic inside the block; results are alu_out truncated by the ALU to 4 bits and passed through unmodified (apart from REQ-028).
REQ-030 rsp_ready while rsp_valid is low has no effect.

Reset
REQ-031 rst asserted at an edge: state IDLE, pointers and count 0, settle counter 0, rsp_valid 0, rsp_data/rsp_op/rsp_dz 0, alu_a/alu_b/alu_op 0, busy 0; cmd_ready 1 after that edge.
REQ-032 Reset mid-operation (ISSUE or RESP, FIFO non-empty) discards in-flight and queued commands; no response is produced for them.
REQ-033 A command offered on the reset edge is not accepted.

Verification (ALU reference model attached to alu_*)
REQ-034 Reset, push {000,3,4}, rsp_ready=1 -> rsp_valid high exactly 2 edges after acceptance, rsp_data=7, rsp_op=000, rsp_dz=0.
REQ-035 rsp_ready=0, offer 6 commands back-to-back -> 5 accepted (1 issued + 4 queued), cmd_ready=0, count=4, busy=1; release rsp_ready -> 5 responses in order.
REQ-036 Push {011,9,0} -> rsp_data=0, rsp_dz=1; then {011,9,2} -> rsp_data=4, rsp_dz=0.
REQ-037 Push {100,6,6}, {101,2,5}, {001,5,3}, {010,5,5} with rsp_ready=1 -> rsp_data 1, 0, 2, 9 (25 mod 16), one every 2 cycles.
REQ-038 rst pulsed while in RESP with count=2 -> after the edge rsp_valid=0, count=0, cmd_ready=1, alu_a=alu_b=alu_op=0, and no further responses appear.
REQ-039 SETTLE=3 build, push {000,15,1} -> rsp_valid 4 edges after acceptance, rsp_data=0 (wrap-around).

Source files
------------

// File: rtl/ula4_issuer.sv
// ----------------------------------------------------------------------------
// ula4_issuer
//
// Queues 4-bit ALU commands {op, a, b} in a small circular FIFO and issues them
// one at a time to an external combinational ALU. Operands are held on the ALU
// ports for SETTLE cycles, then alu_out is captured into a response register.
// The response is held until the consumer takes it. Commands are issued and
// returned strictly in order.
//
// Parameters
//   DEPTH   command FIFO entries (power of two, 2..16)
//   SETTLE  cycles the operands sit on the ALU before alu_out is sampled (1..7)
//
// Ports
//   clk        single clock, rising edge
//   rst        synchronous active-high reset
//   cmd_valid  command offered
//   cmd_ready  FIFO has room (depends on occupancy only)
//   cmd_op     operation code (add, sub, mul, div, eq, gt, lt, ne)
//   cmd_a/b    4-bit operands
//   alu_a/b    registered operands to the ALU
//   alu_op     registered op code to the ALU
//   alu_out    combinational ALU result
//   rsp_valid  response available
//   rsp_ready  response consumed when rsp_valid is also high
//   rsp_data   captured result (forced to 0 on divide by zero)
//   rsp_op     op code of the returned result
//   rsp_dz     divide-by-zero flag
//   busy       FSM not idle
//   count      FIFO occupancy
// ----------------------------------------------------------------------------
module ula4_issuer #(
    parameter int DEPTH  = 4,
    parameter int SETTLE = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [2:0]               cmd_op,
    input  logic [3:0]               cmd_a,
    input  logic [3:0]               cmd_b,
    output logic [3:0]               alu_a,
    output logic [3:0]               alu_b,
    output logic [2:0]               alu_op,
    input  logic [3:0]               alu_out,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [3:0]               rsp_data,
    output logic [2:0]               rsp_op,
    output logic                     rsp_dz,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);
    localparam logic [2:0]  SETTLE_LOAD = 3'(SETTLE);
    localparam logic [2:0]  OP_DIV = 3'b011;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    cmd_t            mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [PW:0]     count_reg;
    logic [PW:0]     count_next;
    state_t          state_reg;
    logic [2:0]      settle_reg;

    logic [3:0]      alu_a_reg;
    logic [3:0]      alu_b_reg;
    logic [2:0]      alu_op_reg;

    logic            rsp_valid_reg;
    logic [3:0]      rsp_data_reg;
    logic [2:0]      rsp_op_reg;
    logic            rsp_dz_reg;

    logic            push;
    logic            pop;
    logic            rsp_hs;
    logic            div_zero;
    cmd_t            cmd_in;

    // ------------------------------------------------------------------
    // Handshake decode
    // ------------------------------------------------------------------
    // cmd_ready looks only at the registered occupancy, so a full FIFO
    // refuses a command even on an edge where an entry is being popped.
    assign cmd_ready = (count_reg < FULL_LEVEL);

    always_comb begin
        cmd_in    = '{op: cmd_op, a: cmd_a, b: cmd_b};
        push      = cmd_valid && cmd_ready && !rst;
        rsp_hs    = rsp_valid_reg && rsp_ready;
        // The head is popped from IDLE whenever something is queued, or on
        // the response handshake edge so back-to-back issue skips IDLE.
        pop       = (count_reg != '0) &&
                    ((state_reg == IDLE) || ((state_reg == RESP) && rsp_hs));
        div_zero  = (alu_op_reg == OP_DIV) && (alu_b_reg == 4'd0);
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + (PW+1)'(1);
            2'b01:   count_next = count_reg - (PW+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // ------------------------------------------------------------------
    // Command storage. No reset: contents are only observed through the
    // pointers, which are reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= cmd_in;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, occupancy, issue FSM and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            state_reg     <= IDLE;
            settle_reg    <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_op_reg    <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_data_reg  <= '0;
            rsp_op_reg    <= '0;
            rsp_dz_reg    <= 1'b0;
        end else begin
            count_reg <= count_next;

            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end

            // The pop edge is the only place the ALU operand registers move;
            // this doubles as the registered read of the command storage.
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
                alu_op_reg <= mem[rd_ptr_reg].op;
                alu_a_reg  <= mem[rd_ptr_reg].a;
                alu_b_reg  <= mem[rd_ptr_reg].b;
                settle_reg <= SETTLE_LOAD;
            end

            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        state_reg <= ISSUE;
                    end
                end

                ISSUE: begin
                    // pop never fires in ISSUE, so this is the only
                    // settle_reg update here.
                    settle_reg <= settle_reg - 3'd1;
                    if (settle_reg == 3'd1) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_op_reg    <= alu_op_reg;
                        rsp_dz_reg    <= div_zero;
                        rsp_data_reg  <= div_zero ? 4'd0 : alu_out;
                        state_reg     <= RESP;
                    end
                end

                RESP: begin
                    if (rsp_hs) begin
                        rsp_valid_reg <= 1'b0;
                        state_reg     <= pop ? ISSUE : IDLE;
                    end
                end

                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign alu_a     = alu_a_reg;
    assign alu_b     = alu_b_reg;
    assign alu_op    = alu_op_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_data  = rsp_data_reg;
    assign rsp_op    = rsp_op_reg;
    assign rsp_dz    = rsp_dz_reg;
    assign busy      = (state_reg != IDLE);
    assign count     = count_reg;

endmodule

// File: tb/tb_ula4_issuer.sv
// ----------------------------------------------------------------------------
// tb_ula4_issuer
//
// Bench for ula4_issuer. Two instances share clk/rst: dut (SETTLE=1) and dut3
// (SETTLE=3). A behavioural ALU drives alu_out for each. Expected responses
// come from a command queue plus plain arithmetic on the queued operands.
// ----------------------------------------------------------------------------
module tb_ula4_issuer;

    typedef struct packed {
        logic [2:0] op;
        logic [3:0] a;
        logic [3:0] b;
    } c_t;

    logic       clk = 1'b0;
    logic       rst;

    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_dz, busy;
    logic [2:0] cmd_op, alu_op, rsp_op;
    logic [3:0] cmd_a, cmd_b, alu_a, alu_b, alu_out, rsp_data;
    logic [2:0] count;

    logic       cmd_valid3, cmd_ready3, rsp_valid3, rsp_ready3, rsp_dz3, busy3;
    logic [2:0] cmd_op3, alu_op3, rsp_op3;
    logic [3:0] cmd_a3, cmd_b3, alu_a3, alu_b3, alu_out3, rsp_data3;
    logic [2:0] count3;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;
    int hs_cnt = 0;
    c_t exp_q[$];
    int hs_cyc[$];

    logic [2:0] t_op [4];
    logic [3:0] t_a  [4];
    logic [3:0] t_b  [4];
    logic [3:0] t_d  [4];

    always #5 clk = ~clk;

    ula4_issuer #(.DEPTH(4), .SETTLE(1)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_out(alu_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_dz(rsp_dz),
        .busy(busy), .count(count)
    );

    ula4_issuer #(.DEPTH(4), .SETTLE(3)) dut3 (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid3), .cmd_ready(cmd_ready3),
        .cmd_op(cmd_op3), .cmd_a(cmd_a3), .cmd_b(cmd_b3),
        .alu_a(alu_a3), .alu_b(alu_b3), .alu_op(alu_op3), .alu_out(alu_out3),
        .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3),
        .rsp_data(rsp_data3), .rsp_op(rsp_op3), .rsp_dz(rsp_dz3),
        .busy(busy3), .count(count3)
    );

    // Behavioural ALU: 4-bit results; divide by zero returns a non-zero value
    // so the zero override in the issuer is visible.
    function automatic logic [3:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                          input logic [3:0] b);
        logic [7:0] w;
        logic [7:0] wa;
        logic [7:0] wb;
        wa = {4'd0, a};
        wb = {4'd0, b};
        case (op)
            3'd0:    w = wa + wb;
            3'd1:    w = wa - wb;
            3'd2:    w = wa * wb;
            3'd3:    w = (b == 4'd0) ? 8'h0F : wa / wb;
            3'd4:    w = {7'd0, a == b};
            3'd5:    w = {7'd0, a > b};
            3'd6:    w = {7'd0, a < b};
            default: w = {7'd0, a != b};
        endcase
        return w[3:0];
    endfunction

    always_comb alu_out  = alu_fn(alu_op, alu_a, alu_b);
    always_comb alu_out3 = alu_fn(alu_op3, alu_a3, alu_b3);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard the dut handshakes about to happen, take the edge,
    // then confirm a stalled response stayed put.
    task automatic cyc();
        logic       held;
        logic [3:0] hd;
        logic [2:0] ho;
        logic       hz;
        c_t         e;
        logic       e_dz;
        logic [3:0] e_d;
        held = !rst && rsp_valid && !rsp_ready;
        hd = rsp_data;
        ho = rsp_op;
        hz = rsp_dz;
        if (!rst && cmd_valid && cmd_ready)
            exp_q.push_back('{op: cmd_op, a: cmd_a, b: cmd_b});
        if (!rst && rsp_valid && rsp_ready) begin
            chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                e_dz = (e.op == 3'd3) && (e.b == 4'd0);
                e_d  = e_dz ? 4'd0 : alu_fn(e.op, e.a, e.b);
                chk("sb_data", 32'(rsp_data), 32'(e_d));
                chk("sb_op",   32'(rsp_op),   32'(e.op));
                chk("sb_dz",   32'(rsp_dz),   32'(e_dz));
                $display("rsp cyc=%0d op=%0d a=%0d b=%0d data=%0d dz=%0d",
                         cycle, e.op, e.a, e.b, rsp_data, rsp_dz);
                hs_cnt++;
                hs_cyc.push_back(cycle);
            end
        end
        @(posedge clk);
        #1;
        cycle++;
        if (rst) exp_q.delete();
        if (held) begin
            chk("hold_valid", 32'(rsp_valid), 32'd1);
            chk("hold_data",  32'({ho, hd, hz}), 32'({rsp_op, rsp_data, rsp_dz}));
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int n;
        n = 0;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_valid = 1'b1;
        while (!cmd_ready && n < 50) begin
            cyc();
            n++;
        end
        if (!cmd_ready) chk("send_ready", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [3:0] d, input logic [2:0] op,
                              input logic dz);
        int n;
        n = 0;
        while (!rsp_valid && n < 20) begin
            cyc();
            n++;
        end
        chk({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_data"},  32'(rsp_data),  32'(d));
        chk({tag, "_op"},    32'(rsp_op),    32'(op));
        chk({tag, "_dz"},    32'(rsp_dz),    32'(dz));
        cyc();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int acc;
        int k;
        int n;
        int extra;
        int hs0;

        // ---------------- reset, with a command offered on the reset edges
        rst = 1'b1;
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'd5; cmd_b = 4'd5;
        rsp_ready = 1'b0;
        cmd_valid3 = 1'b0; cmd_op3 = 3'd0; cmd_a3 = 4'd0; cmd_b3 = 4'd0;
        rsp_ready3 = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cmd_valid = 1'b0;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_count",     32'(count),     32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_alu",       32'({alu_op, alu_a, alu_b}), 32'd0);
        chk("rst_rsp",       32'({rsp_op, rsp_data, rsp_dz}), 32'd0);
        cyc();
        chk("rst_no_accept", 32'(count), 32'd0);
        chk("rst_idle_busy", 32'(busy),  32'd0);

        // ---------------- add 3+4, latency 2 edges
        rsp_ready = 1'b1;
        cmd_op = 3'd0; cmd_a = 4'd3; cmd_b = 4'd4; cmd_valid = 1'b1;
        chk("add_ready", 32'(cmd_ready), 32'd1);
        cyc();
        cmd_valid = 1'b0;
        chk("add_count1",   32'(count),     32'd1);
        chk("add_novalid",  32'(rsp_valid), 32'd0);
        lat = 0;
        while (!rsp_valid && lat < 10) begin
            cyc();
            lat++;
        end
        chk("add_latency", 32'(lat), 32'd2);
        chk("add_data",    32'(rsp_data), 32'd7);
        chk("add_op",      32'(rsp_op),   32'd0);
        chk("add_dz",      32'(rsp_dz),   32'd0);
        cyc();
        chk("add_done_valid", 32'(rsp_valid), 32'd0);
        chk("add_done_busy",  32'(busy),      32'd0);

        // ---------------- SETTLE=3 instance: 15+1 wraps to 0, latency 4
        cmd_op3 = 3'd0; cmd_a3 = 4'd15; cmd_b3 = 4'd1; cmd_valid3 = 1'b1;
        chk("s3_ready", 32'(cmd_ready3), 32'd1);
        cyc();
        cmd_valid3 = 1'b0;
        lat = 0;
        while (!rsp_valid3 && lat < 20) begin
            cyc();
            lat++;
        end
        chk("s3_latency", 32'(lat), 32'd4);
        chk("s3_data",    32'(rsp_data3), 32'd0);
        chk("s3_op",      32'(rsp_op3),   32'd0);
        chk("s3_dz",      32'(rsp_dz3),   32'd0);
        cyc();
        chk("s3_done", 32'(rsp_valid3), 32'd0);

        // ---------------- stall: 6 offered, 5 accepted, then drain in order
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            cmd_op = 3'($urandom_range(0, 7));
            cmd_a  = 4'($urandom_range(0, 15));
            cmd_b  = 4'($urandom_range(0, 15));
            cmd_valid = 1'b1;
            if (cmd_ready) acc++;
            cyc();
        end
        cmd_valid = 1'b0;
        chk("stall_accepted", 32'(acc),       32'd5);
        chk("stall_ready",    32'(cmd_ready), 32'd0);
        chk("stall_count",    32'(count),     32'd4);
        chk("stall_busy",     32'(busy),      32'd1);
        chk("stall_valid",    32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        hs0 = hs_cnt;
        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            cyc();
            n++;
        end
        chk("stall_drained", 32'(exp_q.size()), 32'd0);
        chk("stall_rsp_cnt", 32'(hs_cnt - hs0), 32'd5);

        // ---------------- divide by zero and a normal divide
        send(3'd3, 4'd9, 4'd0);
        expect_rsp("div0", 4'd0, 3'd3, 1'b1);
        send(3'd3, 4'd9, 4'd2);
        expect_rsp("div", 4'd4, 3'd3, 1'b0);

        // ---------------- compare/sub/mul stream, one result per 2 cycles
        t_op = '{3'd4, 3'd5, 3'd1, 3'd2};
        t_a  = '{4'd6, 4'd2, 4'd5, 4'd5};
        t_b  = '{4'd6, 4'd5, 4'd3, 4'd5};
        t_d  = '{4'd1, 4'd0, 4'd2, 4'd9};
        hs_cyc.delete();
        k = 0;
        n = 0;
        while (k < 4 && n < 40) begin
            if (n < 4) begin
                cmd_op = t_op[n]; cmd_a = t_a[n]; cmd_b = t_b[n]; cmd_valid = 1'b1;
                chk("stream_ready", 32'(cmd_ready), 32'd1);
            end else begin
                cmd_valid = 1'b0;
            end
            if (rsp_valid) begin
                chk("stream_data", 32'(rsp_data), 32'(t_d[k]));
                k++;
            end
            cyc();
            n++;
        end
        cmd_valid = 1'b0;
        chk("stream_count", 32'(k), 32'd4);
        chk("stream_hs", 32'(hs_cyc.size()), 32'd4);
        if (hs_cyc.size() == 4) begin
            for (int j = 1; j < 4; j++)
                chk("stream_interval", 32'(hs_cyc[j] - hs_cyc[j-1]), 32'd2);
        end

        // ---------------- reset while in RESP with two queued
        rsp_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmd_op = 3'($urandom_range(0, 7));
            cmd_a  = 4'($urandom_range(0, 15));
            cmd_b  = 4'($urandom_range(1, 15));
            cmd_valid = 1'b1;
            cyc();
        end
        cmd_valid = 1'b0;
        chk("mid_valid", 32'(rsp_valid), 32'd1);
        chk("mid_count", 32'(count),     32'd2);
        rst = 1'b1;
        cmd_valid = 1'b1;
        cyc();
        rst = 1'b0;
        cmd_valid = 1'b0;
        chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
        chk("mid_rst_count", 32'(count),     32'd0);
        chk("mid_rst_ready", 32'(cmd_ready), 32'd1);
        chk("mid_rst_alu",   32'({alu_op, alu_a, alu_b}), 32'd0);
        chk("mid_rst_busy",  32'(busy),      32'd0);
        rsp_ready = 1'b1;
        extra = 0;
        repeat (12) begin
            if (rsp_valid) extra++;
            cyc();
        end
        chk("mid_no_rsp", 32'(extra), 32'd0);

        // ---------------- randomized traffic against the scoreboard
        for (int i = 0; i < 300; i++) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_a     = 4'($urandom_range(0, 15));
            cmd_b     = 4'($urandom_range(0, 3) == 0 ? 0 : $urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            chk("rand_ready", 32'(cmd_ready), 32'(count < 3'd4));
            cyc();
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            cyc();
            n++;
        end
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_busy",    32'(busy),         32'd0);
        chk("rand_valid",   32'(rsp_valid),    32'd0);
        chk("rand_count",   32'(count),        32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
